accel_sequencer: RTL
====================

# accel_sequencer

Instruction sequencer for the accelerator core. Fetches 24-bit instructions from the instruction store, decodes opcode and operand fields, and dispatches each operation to the execution datapath (matrix multiply, vector add, vector move) over a valid/ready issue handshake. It waits for completion, advances the program counter, and stops on halt, illegal opcode or end of program.

## Interface
- INSTR_WIDTH, 24, instruction width; fields are opcode [23:18], op_a [17:13], op_b [12:8], op_c [7:3], op_imm [2:0]
- PROG_LEN, 32, instruction store depth; PC_W = $clog2(PROG_LEN)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin execution at pc 0; honoured only in IDLE or HALTED
- imem_addr  out  PC_W  instruction read address (registered-read store: data valid the cycle after the address is presented)
- imem_data  in  INSTR_WIDTH  instruction read data
- op_valid  out  1  operation issue request
- op_ready  in  1  datapath accepts operation
- op_code  out  6  decoded opcode, held stable while op_valid is high
- op_a, op_b, op_c  out  5 each  operand fields, held with op_code
- op_imm  out  3  immediate field, held with op_code
- op_done  in  1  single-cycle completion pulse from datapath
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- illegal  out  1  sticky; set by an undefined opcode
- pc  out  PC_W  current program counter

## Operation
- Opcodes: 0 = NOP; 1 = MATMUL; 2 = VADD; 3 = VMOV; 10 = HALT; all others are illegal.
- States: IDLE, FETCH, DECODE, ISSUE, EXEC, HALTED.
- IDLE: start -> FETCH with pc = 0, illegal cleared.
- FETCH: drive imem_addr = pc -> DECODE.
- DECODE: latch imem_data into the instruction register and drive the op_* fields from it.
  - NOP: advance.
  - HALT: -> HALTED, pc holds the HALT address.
  - Opcode 1/2/3: -> ISSUE.
  - Illegal: set illegal -> HALTED, pc holds.
- ISSUE: op_valid = 1 until the cycle op_valid & op_ready.
  - On handshake with op_done also high: advance.
  - On handshake without op_done: -> EXEC.
- EXEC: op_valid = 0; wait for op_done, then advance.
- Advance: if pc == PROG_LEN-1 -> HALTED (pc holds); else pc <= pc+1 -> FETCH.
- HALTED: start -> FETCH with pc = 0, illegal cleared. All other inputs are ignored.
- start while busy: ignored.
- op_done outside ISSUE/EXEC: ignored.
- op_ready while op_valid is low: ignored.
- Operand fields pass through unmodified; no arithmetic on them.

## Timing
- Reset (rst = 0 at an edge) sets:
  - state IDLE
  - pc = 0, imem_addr = 0
  - op_valid = 0, op_code/op_a/op_b/op_c/op_imm = 0
  - busy = 0, halted = 0, illegal = 0
- Reset mid-operation (any state): same values at the next edge; an outstanding op_done after reset is ignored.
- All outputs are registered or decoded from state only; no combinational path from op_ready or op_done to any output.
- Start edge to first FETCH: 1 cycle. FETCH to DECODE: 1 cycle.
- NOP cost: 2 cycles.
- Operation issue: op_valid rises 1 cycle after DECODE.
- Operation cost: 3 + (ready wait) + (cycles from handshake to op_done) cycles, counted from FETCH to the next FETCH.
- HALT: halted rises 1 cycle after DECODE of the HALT word.
- op_code and op_a/op_b/op_c/op_imm are stable from DECODE until the next DECODE.

## Test plan
- Basic program: store words 0..3 = 0 (NOP), 4 = 0x0C0820, 5..6 = 0, 7 = 0x280000; start pulse; datapath ready immediately, op_done 4 cycles after handshake. Required: exactly one issue with op_code=3, op_a=0, op_b=8, op_c=4, op_imm=0; halted=1 with pc=7; illegal=0.
- Backpressure: word 0 = 0x040000 (MATMUL), word 1 = 0x280000; op_ready held low 5 cycles. Required: op_valid and the op_* fields stay constant for all 5 cycles; a single handshake; then HALT at pc=1.
- Same-cycle done: word 0 = 0x080004 (VADD, op_imm=4); op_ready and op_done both high in the first ISSUE cycle. Required: no EXEC cycle; FETCH of pc=1 on the next edge.
- Illegal opcode: word 2 = 0x3C0000 (opcode 15). Required: illegal=1, halted=1, pc=2, no op_valid for that word. A following start clears illegal and refetches pc=0.
- End of program: all 32 words NOP. Required: halted=1 with pc=31, 64 cycles after the start edge; no op_valid at any point.
- Reset mid-EXEC: assert rst=0 for one edge while waiting on op_done. Required: all outputs take their reset values at that edge; a later op_done is ignored; state stays IDLE until start.

Source files
------------

// File: rtl/accel_sequencer.sv
// Instruction sequencer: fetches 24-bit words, decodes them and issues MATMUL/VADD/VMOV
// to the execution datapath over a valid/ready handshake, then waits for completion.
module accel_sequencer #(
  parameter int INSTR_WIDTH = 24,
  parameter int PROG_LEN    = 32,
  localparam int PC_W       = $clog2(PROG_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [5:0]             op_code,
  output logic [4:0]             op_a,
  output logic [4:0]             op_b,
  output logic [4:0]             op_c,
  output logic [2:0]             op_imm,
  input  logic                   op_done,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal,
  output logic [PC_W-1:0]        pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [5:0] OPC_NOP    = 6'd0;
  localparam logic [5:0] OPC_MATMUL = 6'd1;
  localparam logic [5:0] OPC_VADD   = 6'd2;
  localparam logic [5:0] OPC_VMOV   = 6'd3;
  localparam logic [5:0] OPC_HALT   = 6'd10;

  logic [2:0]             state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [5:0]             dec_opc;
  logic                   at_end;
  logic [2:0]             adv_state;
  logic [PC_W-1:0]        adv_pc;

  function automatic logic is_dispatch(input logic [5:0] opc);
    return (opc == OPC_MATMUL) || (opc == OPC_VADD) || (opc == OPC_VMOV);
  endfunction

  assign dec_opc = imem_data[23:18];
  assign at_end  = (pc == PC_W'(PROG_LEN - 1));

  // Completing an instruction either moves to the next word or stops on the last one.
  always_comb begin
    adv_state = S_FETCH;
    adv_pc    = pc + 1'b1;
    if (at_end) begin
      adv_state = S_HALTED;
      adv_pc    = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            illegal <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= imem_data;
          if (dec_opc == OPC_NOP) begin
            state <= adv_state;
            pc    <= adv_pc;
          end else if (dec_opc == OPC_HALT) begin
            state <= S_HALTED;
          end else if (is_dispatch(dec_opc)) begin
            state <= S_ISSUE;
          end else begin
            illegal <= 1'b1;
            state   <= S_HALTED;
          end
        end
        S_ISSUE: begin
          if (op_ready) begin
            if (op_done) begin
              state <= adv_state;
              pc    <= adv_pc;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (op_done) begin
            state <= adv_state;
            pc    <= adv_pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs come from registered state only; nothing combinational from op_ready/op_done.
  assign imem_addr = pc;
  assign op_valid  = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) && (state != S_HALTED);
  assign halted    = (state == S_HALTED);
  assign op_code   = ir[23:18];
  assign op_a      = ir[17:13];
  assign op_b      = ir[12:8];
  assign op_c      = ir[7:3];
  assign op_imm    = ir[2:0];

endmodule
